// File: rtl/nibble_fifo_pkg.sv
// Shared types and default sizes for the nibble-to-byte input FIFO.
package nibble_fifo_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [7:0] byte_t;

  typedef enum logic [0:0] {
    HI_WAIT = 1'b0,
    LO_WAIT = 1'b1
  } pack_state_t;

  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned SYNC_DEF  = 2;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin followed by a rising-edge pulse generator.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Pulse is decoded from registered state only, so it is glitch-free and one cycle long.
  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/nibble_byte_fifo.sv
// Pin input stage: synchronises valid/toggle/din, packs nibble pairs (high first) into bytes
// and buffers them in a small FIFO whose head byte is shown on dout; toggle pops the head.
module nibble_byte_fifo
  import nibble_fifo_pkg::*;
#(
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] din,
  input  logic       valid,
  input  logic       toggle,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  logic vpulse;
  logic tpulse;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_valid_sync (
    .clk  (clk),
    .reset(reset),
    .d    (valid),
    .pulse(vpulse)
  );

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_toggle_sync (
    .clk  (clk),
    .reset(reset),
    .d    (toggle),
    .pulse(tpulse)
  );

  // din follows the same depth as valid so the synced nibble lines up with vpulse.
  nibble_t din_sync_q [SYNC_STAGES];
  nibble_t din_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) din_sync_q[i] <= '0;
    end else begin
      din_sync_q[0] <= din;
      for (int i = 1; i < int'(SYNC_STAGES); i++) din_sync_q[i] <= din_sync_q[i-1];
    end
  end

  assign din_sync = din_sync_q[SYNC_STAGES-1];

  // Packer FSM
  pack_state_t state_q, state_d;
  nibble_t     hi_q, hi_d;
  logic        push;
  byte_t       push_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HI_WAIT;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    push      = 1'b0;
    push_byte = {hi_q, din_sync};
    unique case (state_q)
      HI_WAIT: begin
        if (vpulse) begin
          hi_d    = din_sync;
          state_d = LO_WAIT;
        end
      end
      LO_WAIT: begin
        if (vpulse) begin
          push    = 1'b1;
          state_d = HI_WAIT;
        end
      end
      default: state_d = HI_WAIT;
    endcase
  end

  // FIFO storage, pointers and occupancy
  byte_t           mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;
  logic            pop_eff;
  logic            push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CountFull);
  assign pop_eff = tpulse && !empty;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_eff);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_eff) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_eff})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
  assign dout     = empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_nibble_byte_fifo.sv
// Directed bench for nibble_byte_fifo with a byte-queue scoreboard of the FIFO contents.
module tb_nibble_byte_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SYNC  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic       valid;
  logic       toggle;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  logic       ovf_m;

  nibble_byte_fifo #(
    .DEPTH      (DEPTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .din     (din),
    .valid   (valid),
    .toggle  (toggle),
    .dout    (dout),
    .empty   (empty),
    .full    (full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_dout;
    exp_dout = (mq.size() == 0) ? 8'h00 : mq[0];
    check({tag, ".dout"}, dout, exp_dout);
    check({tag, ".empty"}, {7'd0, empty}, {7'd0, mq.size() == 0});
    check({tag, ".full"}, {7'd0, full}, {7'd0, mq.size() == DEPTH});
    check({tag, ".overflow"}, {7'd0, overflow}, {7'd0, ovf_m});
  endtask

  task automatic model_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else ovf_m = 1'b1;
  endtask

  task automatic model_pop();
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    ovf_m = 1'b0;
  endtask

  task automatic send_nibble(input logic [3:0] n);
    @(negedge clk);
    din = n;
    @(negedge clk);
    valid = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    valid = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nibble(b[7:4]);
    send_nibble(b[3:0]);
    model_push(b);
  endtask

  task automatic pulse_toggle();
    @(negedge clk);
    toggle = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    toggle = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    model_pop();
  endtask

  initial begin
    reset  = 1'b1;
    din    = 4'h0;
    valid  = 1'b0;
    toggle = 1'b0;
    ovf_m  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_all("reset");

    // 1: exact latency of the second nibble
    send_nibble(4'hA);
    @(negedge clk);
    din = 4'h5;
    @(negedge clk);
    valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("lat_early.empty", {7'd0, empty}, 8'd1);
    @(posedge clk);
    #1;
    model_push(8'hA5);
    check_all("lat3");
    repeat (SYNC + 2) @(negedge clk);
    valid = 1'b0;
    repeat (SYNC + 2) @(negedge clk);

    // 2: fill, overflow, drain
    do_reset();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    check_all("fill");
    send_byte(8'h55);
    check_all("drop");
    for (int i = 0; i < 4; i++) begin
      pulse_toggle();
      check_all("drain");
    end

    // 3: held-high valid gives a single nibble
    do_reset();
    @(negedge clk);
    din = 4'h3;
    @(negedge clk);
    valid = 1'b1;
    repeat (10) @(negedge clk);
    valid = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    check_all("held");
    send_nibble(4'hC);
    model_push(8'h3C);
    check_all("held_pair");

    // 4: reset discards a partial nibble
    do_reset();
    send_nibble(4'h7);
    do_reset();
    send_byte(8'h12);
    check_all("partial_discard");

    // 5: simultaneous push and pop while full
    do_reset();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_nibble(4'h5);
    @(negedge clk);
    din = 4'h5;
    @(negedge clk);
    valid  = 1'b1;
    toggle = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("same_pre");
    @(posedge clk);
    #1;
    model_pop();
    model_push(8'h55);
    check_all("same_cycle");
    repeat (SYNC + 2) @(negedge clk);
    valid  = 1'b0;
    toggle = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      pulse_toggle();
      check_all("same_drain");
    end

    // 6: toggle on empty is ignored
    do_reset();
    pulse_toggle();
    check_all("pop_empty");
    send_byte(8'h9E);
    check_all("after_empty_pop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
